// File: rtl/compose_pkg.sv
// Shared definitions for the multi-layer composition controller: FSM state
// encoding and default raster/layer geometry.
package compose_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_NUM_LAYERS = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ_BG     = 2'd1,
    WAIT_FETCH = 2'd2,
    COMPOSE    = 2'd3
  } compose_state_e;

endpackage

// File: rtl/raster_xy_counter.sv
// Raster position counter: steps x across a line, y down the frame, and wraps
// both to the origin after the last pixel of the frame.
module raster_xy_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_W      = $clog2(H_ACTIVE),
  parameter int Y_W      = $clog2(V_ACTIVE)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           advance,
  input  logic           clear,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           last_pixel,
  output logic           wrap
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);
  localparam logic [X_W-1:0] X_ONE  = X_W'(32'd1);
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(32'd1);

  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;

  assign pixel_x    = x_r;
  assign pixel_y    = y_r;
  assign last_pixel = (x_r == X_LAST) && (y_r == Y_LAST);
  assign wrap       = advance && last_pixel && !clear;

  // Position registers; clear overrides advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (clear) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (advance) begin
      if (x_r == X_LAST) begin
        x_r <= {X_W{1'b0}};
        y_r <= (y_r == Y_LAST) ? {Y_W{1'b0}} : (y_r + Y_ONE);
      end else begin
        x_r <= x_r + X_ONE;
      end
    end
  end

endmodule

// File: rtl/multi_layer_compose_ctrl.sv
// Sequences background read, layer fetch and pixel write for each output pixel
// of a frame, tracking raster position and background starvation.
module multi_layer_compose_ctrl
  import compose_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int UNDERRUN_W = 16,
  parameter int X_W        = $clog2(H_ACTIVE),
  parameter int Y_W        = $clog2(V_ACTIVE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  layers_ready,
  input  logic                  bg_valid,
  input  logic [NUM_LAYERS-1:0] layer_busy,
  input  logic [NUM_LAYERS-1:0] layer_en,
  input  logic                  wrfull,
  output logic                  bg_rdreq,
  output logic                  fetch_req,
  output logic                  wrreq,
  output logic                  pc_enable,
  output logic [X_W-1:0]        pixel_x,
  output logic [Y_W-1:0]        pixel_y,
  output logic                  frame_done,
  output logic                  busy,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = {UNDERRUN_W{1'b1}};
  localparam logic [UNDERRUN_W-1:0] UNDERRUN_ONE = UNDERRUN_W'(32'd1);

  compose_state_e          state_r;
  logic [NUM_LAYERS-1:0]   en_q_r;
  logic [UNDERRUN_W-1:0]   underrun_r;
  logic                    frame_done_r;
  logic                    bg_rd_s;
  logic                    wr_s;
  logic                    last_s;
  logic                    wrap_s;

  // Strobes decode from the registered state; a restart masks them all.
  always_comb begin
    bg_rd_s = 1'b0;
    wr_s    = 1'b0;
    if (frame_start) begin
      bg_rd_s = 1'b0;
      wr_s    = 1'b0;
    end else begin
      case (state_r)
        REQ_BG:  bg_rd_s = !wrfull && bg_valid;
        COMPOSE: wr_s    = !wrfull;
        default: begin
          bg_rd_s = 1'b0;
          wr_s    = 1'b0;
        end
      endcase
    end
  end

  raster_xy_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (wr_s),
    .clear      (frame_start),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .last_pixel (last_s),
    .wrap       (wrap_s)
  );

  // Control FSM with enable snapshot, starvation counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      en_q_r       <= {NUM_LAYERS{1'b0}};
      underrun_r   <= {UNDERRUN_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
      if (frame_start) begin
        underrun_r <= {UNDERRUN_W{1'b0}};
      end else if ((state_r == REQ_BG) && !wrfull && !bg_valid &&
                   (underrun_r != UNDERRUN_MAX)) begin
        underrun_r <= underrun_r + UNDERRUN_ONE;
      end
      if (frame_start) begin
        state_r <= REQ_BG;
        en_q_r  <= layer_en;
      end else begin
        case (state_r)
          IDLE: begin
            if (layers_ready) begin
              state_r <= REQ_BG;
              en_q_r  <= layer_en;
            end
          end
          REQ_BG: begin
            if (bg_rd_s) state_r <= WAIT_FETCH;
          end
          // Fetchers answer one cycle late, so this state always lasts at least one cycle.
          WAIT_FETCH: begin
            if ((layer_busy & en_q_r) == {NUM_LAYERS{1'b0}}) state_r <= COMPOSE;
          end
          COMPOSE: begin
            if (wr_s) state_r <= last_s ? IDLE : REQ_BG;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign bg_rdreq     = bg_rd_s;
  assign fetch_req    = bg_rd_s;
  assign wrreq        = wr_s;
  assign pc_enable    = wr_s;
  assign frame_done   = frame_done_r;
  assign busy         = (state_r != IDLE);
  assign underrun_cnt = underrun_r;

endmodule

// File: tb/tb_multi_layer_compose_ctrl.sv
// Scoreboard bench: stimulus queues the expected raster order of each frame,
// a negedge monitor pops and compares on every write.
module tb_multi_layer_compose_ctrl;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          layers_ready = 1'b0;
  logic          bg_valid = 1'b0;
  logic          wrfull = 1'b0;
  logic [NL-1:0] layer_busy = '0;
  logic [NL-1:0] layer_en = '0;
  logic          bg_rdreq, fetch_req, wrreq, pc_enable, frame_done, busy;
  logic [1:0]    pixel_x;
  logic [0:0]    pixel_y;
  logic [15:0]   underrun_cnt;
  logic          n_bg, n_fetch, n_wr, n_pc, n_fd, n_busy;
  logic [1:0]    n_x;
  logic [0:0]    n_y;
  logic [1:0]    n_under;

  multi_layer_compose_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .NUM_LAYERS(NL), .UNDERRUN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .layers_ready(layers_ready),
    .bg_valid(bg_valid), .layer_busy(layer_busy), .layer_en(layer_en), .wrfull(wrfull),
    .bg_rdreq(bg_rdreq), .fetch_req(fetch_req), .wrreq(wrreq), .pc_enable(pc_enable),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_done(frame_done), .busy(busy),
    .underrun_cnt(underrun_cnt));

  // Narrow-counter twin, only its saturating counter is examined.
  multi_layer_compose_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .NUM_LAYERS(NL), .UNDERRUN_W(2)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .layers_ready(layers_ready),
    .bg_valid(bg_valid), .layer_busy(layer_busy), .layer_en(layer_en), .wrfull(wrfull),
    .bg_rdreq(n_bg), .fetch_req(n_fetch), .wrreq(n_wr), .pc_enable(n_pc),
    .pixel_x(n_x), .pixel_y(n_y), .frame_done(n_fd), .busy(n_busy),
    .underrun_cnt(n_under));

  always #5 clk = ~clk;

  typedef struct { int x; int y; bit last; } pix_t;
  pix_t exp_q[$];
  int   wr_times[$];
  int   checks = 0, passes = 0;
  int   cyc = 0, writes_seen = 0, frames_done = 0, fetch_cnt = 0;
  bit   exp_fd = 1'b0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: checks every write against the expected raster order.
  initial begin
    pix_t p;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_done || exp_fd) check("frame_done", frame_done, exp_fd);
        if (frame_done) frames_done++;
        exp_fd = 1'b0;
        if (fetch_req) fetch_cnt++;
        if (bg_rdreq || fetch_req) check("fetch_req_eq_bg_rdreq", fetch_req, bg_rdreq);
        if (wrreq || pc_enable) check("pc_enable_eq_wrreq", pc_enable, wrreq);
        if (wrreq) begin
          writes_seen++;
          wr_times.push_back(cyc);
          if (exp_q.size() == 0) check("unexpected_write", 1, 0);
          else begin
            p = exp_q.pop_front();
            check("pixel_x", pixel_x, p.x);
            check("pixel_y", pixel_y, p.y);
            exp_fd = p.last;
          end
        end
      end else begin
        exp_fd = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_frame();
    exp_q.delete();
    for (int i = 0; i < H * V; i++)
      exp_q.push_back('{x: i % H, y: i / H, last: (i == H * V - 1)});
  endfunction

  task automatic start_frame(input bit use_ready);
    push_frame();
    if (use_ready) layers_ready = 1'b1;
    else frame_start = 1'b1;
    tick();
    layers_ready = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start, n;
    start = frames_done;
    n = 0;
    while (frames_done == start && n < budget) begin
      tick();
      n++;
    end
    check({name, "_frame_done_seen"}, frames_done != start, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_idle_after"}, busy, 0);
  endtask

  task automatic wait_fetch(output int fc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fetch_req && n < 50);
    check("wait_fetch_seen", fetch_req, 1);
    fc = cyc;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bg_rdreq"}, bg_rdreq, 0);
    check({tag, "_fetch_req"}, fetch_req, 0);
    check({tag, "_wrreq"}, wrreq, 0);
    check({tag, "_pc_enable"}, pc_enable, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_pixel_x"}, pixel_x, 0);
    check({tag, "_pixel_y"}, pixel_y, 0);
    check({tag, "_underrun"}, underrun_cnt, 0);
  endtask

  initial begin
    int fs_cyc, fcyc, w0, base, f0, n, d0, acts;

    repeat (3) tick();
    @(negedge clk);
    check_reset("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Uncontended frame: eight writes, three cycles apart.
    bg_valid = 1'b1; wrfull = 1'b0; layer_busy = '0; layer_en = '0;
    wr_times.delete();
    f0 = fetch_cnt;
    fs_cyc = cyc;
    start_frame(1'b0);
    wait_done("t1", 100);
    check("t1_write_count", wr_times.size(), 8);
    check("t1_fetch_count", fetch_cnt - f0, 8);
    if (wr_times.size() > 0) check("t1_first_latency", wr_times[0] - fs_cyc, 3);
    for (int i = 1; i < wr_times.size(); i++) check("t1_spacing", wr_times[i] - wr_times[i-1], 3);

    // Enabled layer 0 stalls, disabled layer 1 ignored, live enable change ignored.
    layer_en = 4'b0101;
    wr_times.delete();
    start_frame(1'b0);
    layer_en = 4'b0010;
    wait_fetch(fcyc);
    tick();
    layer_busy = 4'b0011;
    repeat (4) tick();
    tick();
    layer_busy = 4'b0010;
    wait_done("t2", 200);
    check("t2_fetch_to_write", (wr_times.size() > 0) ? wr_times[0] - fcyc : -1, 7);
    layer_busy = '0; layer_en = '0;

    // Output FIFO full for ten cycles in COMPOSE.
    start_frame(1'b0);
    wait_fetch(fcyc);
    tick();
    wrfull = 1'b1;
    w0 = writes_seen;
    repeat (11) tick();
    check("t3_no_write_while_full", writes_seen - w0, 0);
    check("t3_hold_x", pixel_x, 0);
    check("t3_hold_y", pixel_y, 0);
    wrfull = 1'b0;
    tick();
    check("t3_write_on_release", writes_seen - w0, 1);
    tick();
    check("t3_single_write", writes_seen - w0, 1);
    wait_done("t3", 100);

    // Background starvation: 7 cycles, then 2 more to show saturation.
    bg_valid = 1'b0;
    start_frame(1'b0);
    repeat (7) tick();
    bg_valid = 1'b1;
    @(negedge clk);
    check("t4_underrun_7", underrun_cnt, 7);
    check("t4_narrow_sat_7", n_under, 3);
    tick();
    bg_valid = 1'b0;
    repeat (4) tick();
    bg_valid = 1'b1;
    @(negedge clk);
    check("t4_underrun_9", underrun_cnt, 9);
    check("t4_narrow_sat_9", n_under, 3);
    wait_done("t4", 100);
    check("t4_underrun_kept", underrun_cnt, 9);

    // Restart at pixel (2,1).
    bg_valid = 1'b0;
    base = writes_seen;
    start_frame(1'b0);
    repeat (3) tick();
    bg_valid = 1'b1;
    n = 0;
    while (writes_seen != base + 6 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_six_writes", writes_seen - base, 6);
    check("t5_underrun_pre", underrun_cnt, 3);
    repeat (3) tick();
    frame_start = 1'b1;
    push_frame();
    @(negedge clk);
    check("t5_no_wrreq", wrreq, 0);
    check("t5_no_bg_rdreq", bg_rdreq, 0);
    check("t5_no_fetch_req", fetch_req, 0);
    check("t5_at_x2", pixel_x, 2);
    check("t5_at_y1", pixel_y, 1);
    tick();
    frame_start = 1'b0;
    check("t5_underrun_cleared", underrun_cnt, 0);
    wait_done("t5", 100);

    // Reset during WAIT_FETCH, then quiet until a new start.
    start_frame(1'b0);
    wait_fetch(fcyc);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset("t6");
    tick();
    tick();
    rst_n = 1'b1;
    acts = 0;
    repeat (10) begin
      @(negedge clk);
      if (bg_rdreq || fetch_req || wrreq || pc_enable || busy || frame_done) acts++;
    end
    check("t6_quiet_after_reset", acts, 0);
    tick();

    // Randomized frames against the raster-order scoreboard.
    for (int f = 0; f < 4; f++) begin
      layer_en = NL'($urandom);
      start_frame(f[0]);
      n = 0;
      d0 = frames_done;
      while (frames_done == d0 && n < 3000) begin
        bg_valid   = ($urandom_range(0, 3) != 0);
        wrfull     = ($urandom_range(0, 3) == 0);
        layer_busy = NL'($urandom & $urandom);
        layer_en   = NL'($urandom);
        tick();
        n++;
      end
      check("rand_frame_done_seen", frames_done != d0, 1);
      check("rand_queue_empty", exp_q.size(), 0);
      wrfull = 1'b0;
      layer_busy = '0;
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_layer_compose_ctrl.md
MULTI_LAYER_COMPOSE_CTRL -- requirements
Module: multi_layer_compose_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter NUM_LAYERS, default 4, number of sprite/layer fetchers.
REQ-004 Parameter UNDERRUN_W, default 16, width of underrun counter.
REQ-005 Derived: X_W = clog2(H_ACTIVE), Y_W = clog2(V_ACTIVE).
REQ-006 clk  in  1  system clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 frame_start  in  1  one-cycle pulse, begin or restart frame.
REQ-009 layers_ready  in  1  layer descriptors loaded, composition may start.
REQ-010 bg_valid  in  1  background FIFO holds a pixel.
REQ-011 layer_busy  in  NUM_LAYERS  per-layer fetch in progress; registered response, visible the cycle after fetch_req.
REQ-012 layer_en  in  NUM_LAYERS  per-layer enable mask.
REQ-013 wrfull  in  1  output pixel FIFO full.
REQ-014 bg_rdreq  out  1  background FIFO read strobe.
REQ-015 fetch_req  out  1  start pulse to all layer fetchers.
REQ-016 wrreq  out  1  output FIFO write strobe.
REQ-017 pc_enable  out  1  composer pixel advance strobe, identical to wrreq.
REQ-018 pixel_x  out  X_W  current pixel column.
REQ-019 pixel_y  out  Y_W  current pixel row.
REQ-020 frame_done  out  1  registered one-cycle pulse after last pixel written.
REQ-021 busy  out  1  high whenever state != IDLE.
REQ-022 underrun_cnt  out  UNDERRUN_W  saturating count of background-starved cycles.

Function
REQ-023 FSM states SHALL be IDLE, REQ_BG, WAIT_FETCH, COMPOSE.
REQ-024 IDLE: frame_start or layers_ready -> REQ_BG; layer_en latched into en_q on that transition.
REQ-025 REQ_BG: if !wrfull and bg_valid, bg_rdreq=1 and fetch_req=1 same cycle (combinational), next WAIT_FETCH; else hold.
REQ-026 REQ_BG: each cycle with !wrfull and !bg_valid SHALL increment underrun_cnt, saturating at all-ones.
REQ-027 WAIT_FETCH: exit to COMPOSE when (layer_busy & en_q) == 0; minimum one cycle in WAIT_FETCH.
REQ-028 en_q == 0: WAIT_FETCH exits after exactly one cycle.
REQ-029 COMPOSE: if !wrfull, wrreq=1 and pc_enable=1; else hold with both low.
REQ-030 On write: pixel_x==H_ACTIVE-1 -> pixel_x=0, pixel_y+1; else pixel_x+1.
REQ-031 Write at (H_ACTIVE-1, V_ACTIVE-1): counters wrap to (0,0), next IDLE, frame_done high next cycle.
REQ-032 Otherwise after write: next REQ_BG; minimum throughput 3 cycles per pixel.
REQ-033 frame_start in any non-IDLE state SHALL take priority: strobes forced low that cycle, counters cleared, en_q reloaded, next REQ_BG.
REQ-034 frame_start coincident with last-pixel write: write suppressed, no frame_done, restart per REQ-033.
REQ-035 layer_en changes mid-frame SHALL have no effect until next en_q load.
REQ-036 underrun_cnt SHALL clear on frame_start only; no wrap.
REQ-037 Strobes bg_rdreq, fetch_req, wrreq, pc_enable SHALL be low outside their stated conditions.

Reset
REQ-038 On rst_n low: state IDLE, pixel_x=0, pixel_y=0, en_q=0, underrun_cnt=0, frame_done=0, all strobes low, busy low.
REQ-039 Reset mid-frame SHALL abort immediately; no partial strobes after rst_n deasserts.

Structure
REQ-040 Package compose_pkg SHALL hold the state enum and default H_ACTIVE/V_ACTIVE/NUM_LAYERS constants.
REQ-041 One sub-module raster_xy_counter (advance, clear, wrap, last-pixel flag) SHALL implement REQ-030/031.

Verification
REQ-042 H_ACTIVE=4, V_ACTIVE=2, bg_valid=1, busy=0, en=0: 8 wrreq, 3 cycles apart, frame_done 1 cycle after 8th, state IDLE.
REQ-043 en=4'b0101, layer_busy[0] high 5 cycles, layer_busy[1] held high: COMPOSE entered after layer 0 clears, layer 1 ignored.
REQ-044 wrfull high 10 cycles in COMPOSE: no wrreq, counters hold, single write when released.
REQ-045 bg_valid low 7 cycles in REQ_BG: underrun_cnt=7; with UNDERRUN_W=2 saturates at 3.
REQ-046 frame_start at pixel (2,1): no strobes that cycle, next write at (0,0), underrun_cnt=0.
REQ-047 rst_n low during WAIT_FETCH: all outputs at reset values; after release, no activity until frame_start.
